adder_driver: RTL

Sequential initiator for the adder interface: accepts operand triples through a valid/ready input port, buffers them in a small FIFO, and drives them one at a time onto the `adder_a`/`adder_b`/`adder_cin` ports of the adder. It holds each operand set stable for a fixed settle time, samples `adder_sum`/`adder_cout`, checks them against an internally computed reference, and presents the result on a valid/ready output port. It sits between the test stimulus source and the adder wrapper, and also serves as a self-checking harness for the P4 adder.

---
 rtl/adder_driver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adder_driver.sv
// ============================================================================
// adder_driver: buffers operand triples, drives them onto an adder for SETTLE
// cycles, samples and checks the result, and presents it on a valid/ready port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_driver #(
  parameter int N_BIT  = 32,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] in_a,
  input  logic [N_BIT-1:0] in_b,
  input  logic             in_cin,
  output logic [N_BIT-1:0] adder_a,
  output logic [N_BIT-1:0] adder_b,
  output logic             adder_cin,
  input  logic [N_BIT-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] out_sum,
  output logic             out_cout,
  output logic             out_mismatch,
  output logic [15:0]      err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW = 2 * N_BIT + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_BIT-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              cin_q, cin_d, cout_q, cout_d;
  logic              valid_q, valid_d, mis_q, mis_d;
  logic [15:0]       err_count_q, err_count_d;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              full_w, empty_w, push_w, pop_w;
  logic [EW-1:0]     head_w;
  logic [N_BIT:0]    ref_w;

  // Full when the pointers differ only in the wrap bit.
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign in_ready = !full_w;
  assign push_w  = in_valid && !full_w;
  assign pop_w   = (state_q == S_IDLE) && !empty_w;
  assign head_w  = mem_q[rd_ptr_q[AW-1:0]];

  assign ref_w = {1'b0, a_q} + {1'b0, b_q} + {{N_BIT{1'b0}}, cin_q};

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q[AW-1:0]] <= {in_cin, in_b, in_a};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    valid_d     = valid_q;
    mis_d       = mis_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_w) begin
          a_d     = head_w[N_BIT-1:0];
          b_d     = head_w[2*N_BIT-1:N_BIT];
          cin_d   = head_w[2*N_BIT];
          cnt_d   = CW'(SETTLE - 1);
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sum_d   = adder_sum;
          cout_d  = adder_cout;
          mis_d   = ({adder_cout, adder_sum} != ref_w);
          valid_d = 1'b1;
          if (({adder_cout, adder_sum} != ref_w) && (err_count_q != 16'hFFFF))
            err_count_d = err_count_q + 16'd1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign adder_a      = a_q;
  assign adder_b      = b_q;
  assign adder_cin    = cin_q;
  assign out_valid    = valid_q;
  assign out_sum      = sum_q;
  assign out_cout     = cout_q;
  assign out_mismatch = mis_q;
  assign err_count    = err_count_q;

endmodule

`default_nettype wire
